aes_sub_bytes_iter: RTL

AES_SUB_BYTES_ITER -- requirements
Module: aes_sub_bytes_iter

---
 rtl/aes_sub_bytes_iter.sv | 212 +++++++++++++++++++++
 1 files changed

// File: rtl/aes_sub_bytes_iter.sv
`default_nettype none

// +--------------------------------------------------------------------+
// | aes_sub_bytes_iter: iterative composite-field AES (Inv)SubBytes    |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+

package aes_pkg;

   // GF(2^4) uses x^4+x+1; GF((2^4)^2) uses y^2+y+LAMBDA (trace of 0xC is 1, so irreducible).
   localparam logic [3:0] LAMBDA = 4'hC;

   function automatic logic [3:0] gf4_mul(input logic [3:0] a, input logic [3:0] b);
      logic [3:0] acc;
      logic [3:0] sh;
      acc = 4'h0;
      sh  = a;
      for (int i = 0; i < 4; i++) begin
         if (b[i]) acc = acc ^ sh;
         sh = {sh[2:0], 1'b0} ^ {2'b00, sh[3], sh[3]};
      end
      return acc;
   endfunction

   function automatic logic [3:0] gf4_sq(input logic [3:0] a);
      return {a[3], a[3] ^ a[1], a[2], a[2] ^ a[0]};
   endfunction

   function automatic logic [3:0] gf4_mul_lambda(input logic [3:0] a);
      return gf4_mul(a, LAMBDA);
   endfunction

   // a^14 is the multiplicative inverse in GF(16) and maps 0 to 0.
   function automatic logic [3:0] gf4_inv(input logic [3:0] a);
      logic [3:0] a2;
      logic [3:0] a4;
      logic [3:0] a8;
      a2 = gf4_sq(a);
      a4 = gf4_sq(a2);
      a8 = gf4_sq(a4);
      return gf4_mul(gf4_mul(a2, a4), a8);
   endfunction

   function automatic logic [7:0] gf8c_mul(input logic [7:0] a, input logic [7:0] b);
      logic [3:0] hh;
      hh = gf4_mul(a[7:4], b[7:4]);
      return {hh ^ gf4_mul(a[7:4], b[3:0]) ^ gf4_mul(a[3:0], b[7:4]),
              gf4_mul_lambda(hh) ^ gf4_mul(a[3:0], b[3:0])};
   endfunction

   // (h*y + l)^-1 = (h*y + (h^l)) / (LAMBDA*h^2 + (h^l)*l)
   function automatic logic [7:0] gf8c_inv(input logic [7:0] a);
      logic [3:0] h;
      logic [3:0] l;
      logic [3:0] di;
      h  = a[7:4];
      l  = a[3:0];
      di = gf4_inv(gf4_mul_lambda(gf4_sq(h)) ^ gf4_mul(h ^ l, l));
      return {gf4_mul(h, di), gf4_mul(h ^ l, di)};
   endfunction

   // Linear map given by eight packed 8-bit columns (column i = image of bit i).
   function automatic logic [7:0] iso_map(input logic [7:0] x, input logic [63:0] cols);
      logic [7:0] y;
      y = 8'h00;
      for (int i = 0; i < 8; i++) begin
         if (x[i]) y = y ^ cols[8*i +: 8];
      end
      return y;
   endfunction

   // Columns are powers of a root of the AES polynomial found in the composite field.
   function automatic logic [63:0] iso_fwd_cols();
      logic [7:0]  root;
      logic [7:0]  beta;
      logic [7:0]  pw;
      logic [7:0]  p;
      logic [63:0] cols;
      logic        found;
      root  = 8'h02;
      found = 1'b0;
      cols  = 64'h0;
      for (int r = 2; r < 256; r++) begin
         beta = 8'(r);
         pw   = 8'h01;
         p    = 8'h01;
         for (int k = 1; k <= 8; k++) begin
            pw = gf8c_mul(pw, beta);
            if (k == 1 || k == 3 || k == 4 || k == 8) p = p ^ pw;
         end
         if (!found && p == 8'h00) begin
            root  = beta;
            found = 1'b1;
         end
      end
      pw = 8'h01;
      for (int i = 0; i < 8; i++) begin
         cols[8*i +: 8] = pw;
         pw = gf8c_mul(pw, root);
      end
      return cols;
   endfunction

   function automatic logic [63:0] iso_inv_cols(input logic [63:0] fwd);
      logic [63:0] cols;
      cols = 64'h0;
      for (int j = 0; j < 8; j++) begin
         for (int x = 0; x < 256; x++) begin
            if (iso_map(8'(x), fwd) == (8'h01 << j)) cols[8*j +: 8] = 8'(x);
         end
      end
      return cols;
   endfunction

   function automatic logic [7:0] affine_fwd(input logic [7:0] x);
      return x ^ {x[6:0], x[7]} ^ {x[5:0], x[7:6]} ^ {x[4:0], x[7:5]} ^ {x[3:0], x[7:4]} ^ 8'h63;
   endfunction

   function automatic logic [7:0] affine_inv(input logic [7:0] x);
      return {x[6:0], x[7]} ^ {x[4:0], x[7:5]} ^ {x[1:0], x[7:2]} ^ 8'h05;
   endfunction

endpackage

module aes_sub_bytes_iter #(
   parameter int BYTES_PER_CYCLE = 4
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [127:0] in_state,
   input  logic         in_inv,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [127:0] out_state,
   output logic         busy
);

   localparam int GROUPS   = 16 / BYTES_PER_CYCLE;
   localparam int CNT_W    = (GROUPS > 1) ? $clog2(GROUPS) : 1;
   localparam int LANE_W   = 8 * BYTES_PER_CYCLE;
   localparam int LANE_SH  = $clog2(LANE_W);
   localparam logic [CNT_W-1:0] LAST_GRP = CNT_W'(GROUPS - 1);
   localparam logic [63:0] ISO_FWD = aes_pkg::iso_fwd_cols();
   localparam logic [63:0] ISO_INV = aes_pkg::iso_inv_cols(ISO_FWD);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_BUSY = 2'd1;
   localparam logic [1:0] S_DONE = 2'd2;

   logic [1:0]        state;
   logic [CNT_W-1:0]  grp;
   logic [127:0]      cap_state;
   logic              cap_inv;
   logic [127:0]      res_state;
   logic [6:0]        grp_base;
   logic [LANE_W-1:0] grp_in;
   logic [LANE_W-1:0] grp_out;

   assign grp_base = 7'(grp) << LANE_SH;
   assign grp_in   = cap_state[grp_base +: LANE_W];

   // One shared inverter per lane; the mode only selects which affine stage is active.
   for (genvar i = 0; i < BYTES_PER_CYCLE; i++) begin : g_lane
      logic [7:0] b_in;
      logic [7:0] pre;
      logic [7:0] core;
      assign b_in = grp_in[8*i +: 8];
      assign pre  = cap_inv ? aes_pkg::affine_inv(b_in) : b_in;
      assign core = aes_pkg::iso_map(aes_pkg::gf8c_inv(aes_pkg::iso_map(pre, ISO_FWD)), ISO_INV);
      assign grp_out[8*i +: 8] = cap_inv ? core : aes_pkg::affine_fwd(core);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= S_IDLE;
         grp       <= '0;
         cap_state <= 128'h0;
         cap_inv   <= 1'b0;
         res_state <= 128'h0;
      end else begin
         case (state)
            S_IDLE: begin
               if (in_valid) begin
                  cap_state <= in_state;
                  cap_inv   <= in_inv;
                  grp       <= '0;
                  state     <= S_BUSY;
               end
            end
            S_BUSY: begin
               res_state[grp_base +: LANE_W] <= grp_out;
               grp <= (grp == LAST_GRP) ? '0 : grp + 1'b1;
               if (grp == LAST_GRP) state <= S_DONE;
            end
            S_DONE: begin
               if (out_ready) state <= S_IDLE;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

   assign in_ready  = (state == S_IDLE);
   assign out_valid = (state == S_DONE);
   assign busy      = (state != S_IDLE);
   assign out_state = res_state;

endmodule

`default_nettype wire
